// File: rtl/vita_tx_deframer_mc.sv
// Multi-channel VITA-49 TX deframer: parses headers, packs interleaved payload into lines, buffers lines in a FWFT FIFO.
// Optional build macro STREAMID_FILTER_EN drops packets whose stream ID differs from the BASE+1 setting.
module vita_tx_deframer_mc #(
    parameter int unsigned BASE             = 0,
    parameter int unsigned MAXCHAN          = 4,
    parameter int unsigned USE_TRANS_HEADER = 0,
    parameter int unsigned FIFO_DEPTH_LOG2  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      clear_seqnum,
    input  logic                      set_stb,
    input  logic [7:0]                set_addr,
    input  logic [31:0]               set_data,
    input  logic [35:0]               data_i,
    input  logic                      src_rdy_i,
    output logic                      dst_rdy_o,
    output logic [85+32*MAXCHAN-1:0]  sample_fifo_o,
    output logic                      sample_fifo_src_rdy_o,
    input  logic                      sample_fifo_dst_rdy_i,
    output logic [31:0]               current_seqnum,
    output logic [15:0]               seq_err_count,
    output logic [15:0]               fifo_occupied,
    output logic [31:0]               debug
);

    localparam int unsigned LINE_W = 85 + 32*MAXCHAN;
    localparam int unsigned AW     = FIFO_DEPTH_LOG2;
    localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned OCC_W  = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [3:0] {
        TRANS_HEADER, HEADER, STREAMID, CLASSID, CLASSID2, SECS, TICS, TICS2,
        PAYLOAD, STORE, ZFILL, TRAILER, DUMP
    } state_t;

    localparam state_t HDR_ST = (USE_TRANS_HEADER != 0) ? TRANS_HEADER : HEADER;

    state_t state, state_nxt;

    logic [2:0]  numchan_r;
    logic        trailer_r, cid_r, secs_r, tics_r, sob_r, eob_r, has_secs_r;
    logic [15:0] len_r;
    logic [2:0]  phase;
    logic [31:0] lanes [MAXCHAN];
    logic        line_last_r, eof_r;
    logic [63:0] send_time;
    logic [3:0]  line_seq_r;
    logic [31:0] seqnum_reg;
    logic [3:0]  vita_seqnum_reg;
    logic        trans_err_r, seq_err_r;

    logic [LINE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [LINE_W-1:0] line;

    logic xfer, eof, line_done, no_payload, vita_eof, last, fifo_space, wr_en, rd_en;
    logic d_sid, d_cid, d_secs, d_tics, vita_err, pkt_err, sid_drop;
    logic [15:0] trl_cnt;

    assign xfer       = src_rdy_i & dst_rdy_o;
    assign eof        = data_i[33];
    assign dst_rdy_o  = (state != STORE) && (state != ZFILL);
    assign line_done  = (phase == numchan_r);
    assign trl_cnt    = {15'd0, trailer_r};
    assign no_payload = (len_r == trl_cnt);
    assign vita_eof   = (len_r == trl_cnt + 16'd1);
    assign last       = eof | vita_eof;
    assign fifo_space = (occ != OCC_W'(DEPTH));
    assign wr_en      = (state == STORE) && fifo_space;
    assign rd_en      = sample_fifo_src_rdy_o & sample_fifo_dst_rdy_i;

    assign d_sid    = (data_i[31:28] == 4'b0001);
    assign d_cid    = data_i[27];
    assign d_secs   = (data_i[23:22] != 2'b00);
    assign d_tics   = (data_i[21:20] != 2'b00);
    assign vita_err = (data_i[19:16] != vita_seqnum_reg + 4'd1);
    assign pkt_err  = vita_err | ((USE_TRANS_HEADER != 0) && trans_err_r);

    // Settings: channel count (clamped) and, when filtering, the expected stream ID
    always_ff @(posedge clk) begin
        if (reset)
            numchan_r <= 3'd0;
        else if (set_stb && set_addr == 8'(BASE))
            numchan_r <= (32'(set_data[2:0]) >= MAXCHAN) ? 3'(MAXCHAN-1) : set_data[2:0];
    end

`ifdef STREAMID_FILTER_EN
    logic [31:0] streamid_r;
    always_ff @(posedge clk) begin
        if (reset)
            streamid_r <= 32'd0;
        else if (set_stb && set_addr == 8'(BASE+1))
            streamid_r <= set_data;
    end
    assign sid_drop = (data_i[31:0] != streamid_r);
`else
    assign sid_drop = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{data_i[35:34], data_i[32], set_data[31:3]};

    // First header field still to be skipped, given the remaining flags
    function automatic state_t after_hdr(input logic sid, input logic cid,
                                         input logic sec, input logic tic);
        if (sid)      return STREAMID;
        else if (cid) return CLASSID;
        else if (sec) return SECS;
        else if (tic) return TICS;
        else          return PAYLOAD;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clear) state <= HDR_ST;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TRANS_HEADER: if (xfer && !eof) state_nxt = HEADER;
            HEADER:   if (xfer) state_nxt = eof ? HDR_ST : after_hdr(d_sid, d_cid, d_secs, d_tics);
            STREAMID: if (xfer) state_nxt = eof ? HDR_ST :
                                           sid_drop ? DUMP : after_hdr(1'b0, cid_r, secs_r, tics_r);
            CLASSID:  if (xfer) state_nxt = eof ? HDR_ST : CLASSID2;
            CLASSID2: if (xfer) state_nxt = eof ? HDR_ST : after_hdr(1'b0, 1'b0, secs_r, tics_r);
            SECS:     if (xfer) state_nxt = eof ? HDR_ST : after_hdr(1'b0, 1'b0, 1'b0, tics_r);
            TICS:     if (xfer) state_nxt = eof ? HDR_ST : TICS2;
            TICS2:    if (xfer) state_nxt = eof ? HDR_ST : PAYLOAD;
            PAYLOAD: begin
                if (xfer) begin
                    if (no_payload)     state_nxt = eof ? HDR_ST : DUMP;
                    else if (line_done) state_nxt = STORE;
                    else if (last)      state_nxt = ZFILL;
                end
            end
            ZFILL:    state_nxt = STORE;
            STORE: begin
                if (fifo_space) begin
                    if (!line_last_r)   state_nxt = PAYLOAD;
                    else if (eof_r)     state_nxt = HDR_ST;
                    else if (trailer_r) state_nxt = TRAILER;
                    else                state_nxt = DUMP;
                end
            end
            TRAILER:  if (xfer) state_nxt = eof ? HDR_ST : DUMP;
            DUMP:     if (xfer && eof) state_nxt = HDR_ST;
            default:  state_nxt = HDR_ST;
        endcase
    end

    // Header fields, length tracking and line flags
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            trailer_r   <= 1'b0;
            cid_r       <= 1'b0;
            secs_r      <= 1'b0;
            tics_r      <= 1'b0;
            sob_r       <= 1'b0;
            eob_r       <= 1'b0;
            has_secs_r  <= 1'b0;
            len_r       <= 16'd0;
            phase       <= 3'd0;
            line_last_r <= 1'b0;
            eof_r       <= 1'b0;
            send_time   <= 64'd0;
            line_seq_r  <= 4'd0;
            trans_err_r <= 1'b0;
            seq_err_r   <= 1'b0;
        end else if (xfer) begin
            len_r <= len_r - 16'd1;
            case (state)
                TRANS_HEADER: trans_err_r <= (data_i[31:0] != seqnum_reg + 32'd1);
                HEADER: begin
                    trailer_r  <= data_i[26];
                    cid_r      <= d_cid;
                    secs_r     <= d_secs;
                    tics_r     <= d_tics;
                    sob_r      <= data_i[25];
                    eob_r      <= data_i[24];
                    has_secs_r <= d_secs;
                    len_r      <= data_i[15:0] - 16'd1;
                    phase      <= 3'd0;
                    send_time  <= 64'd0;
                    line_seq_r <= data_i[19:16];
                    seq_err_r  <= pkt_err;
                end
                SECS:  send_time[63:32] <= data_i[31:0];
                TICS2: send_time[31:0]  <= data_i[31:0];
                PAYLOAD: begin
                    if (!no_payload) begin
                        phase       <= (line_done || last) ? 3'd0 : phase + 3'd1;
                        line_last_r <= last;
                        eof_r       <= eof;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lane capture; the first word of a line zeroes all other lanes
    always_ff @(posedge clk) begin
        if (xfer && state == PAYLOAD && !no_payload) begin
            for (int i = 0; i < int'(MAXCHAN); i++) begin
                if (3'(i) == phase)   lanes[i] <= data_i[31:0];
                else if (phase == 3'd0) lanes[i] <= 32'd0;
            end
        end
    end

    // Sequence tracking and saturating error counter
    always_ff @(posedge clk) begin
        if (reset || clear || clear_seqnum) begin
            seqnum_reg      <= 32'hFFFF_FFFF;
            vita_seqnum_reg <= 4'hF;
        end else if (xfer) begin
            if (state == TRANS_HEADER) seqnum_reg      <= data_i[31:0];
            if (state == HEADER)       vita_seqnum_reg <= data_i[19:16];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_seqnum)
            seq_err_count <= 16'd0;
        else if (xfer && state == HEADER && pkt_err && seq_err_count != 16'hFFFF)
            seq_err_count <= seq_err_count + 16'd1;
    end

    assign current_seqnum = seqnum_reg;

    always_comb begin
        line = '0;
        for (int i = 0; i < int'(MAXCHAN); i++)
            line[85 + 32*i +: 32] = lanes[i];
        line[84:0] = {seq_err_r, has_secs_r, sob_r, eob_r, line_last_r, 12'd0, line_seq_r, send_time};
    end

    // First-word-fall-through line FIFO
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= line;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

    assign sample_fifo_o         = mem[rd_ptr];
    assign sample_fifo_src_rdy_o = (occ != '0);
    assign fifo_occupied         = 16'(occ);

    assign debug = {16'd0, eof, line_done, (state == STORE), fifo_space, src_rdy_i, dst_rdy_o,
                    phase[1:0], has_secs_r, sob_r, eob_r, line_last_r, state};

endmodule
